// File: rtl/vram_fill_ctrl.sv
// rtl/vram_fill_ctrl.sv - block fill engine for the char / fg colour / bg colour video RAMs
//
// Purpose: the CPU programs address, length, stride, value and target mask through an
// 8-entry register window; the engine then writes the value into the selected RAMs one
// location per cycle, yielding to the CPU and optionally confining itself to vblank.
//
// Ports:
//   clk_sys, reset_n             clock, asynchronous active-low reset
//   reg_cs/reg_wr/reg_addr/din   register window write side
//   reg_dout                     register read data (combinational from reg_addr)
//   cpu_vram_req                 CPU owns the video RAM port this cycle
//   vblank                       vertical blank
//   fill_addr/fill_data/fill_we  write port towards the RAM muxes ([0] ch, [1] fg, [2] bg)
//   busy, done                   engine active / sticky completion flag
module vram_fill_ctrl #(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 12
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              reg_cs,
    input  logic              reg_wr,
    input  logic [2:0]        reg_addr,
    input  logic [7:0]        reg_din,
    output logic [7:0]        reg_dout,
    input  logic              cpu_vram_req,
    input  logic              vblank,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [7:0]        fill_data,
    output logic [2:0]        fill_we,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

    // Programming registers
    logic              wr_q;
    logic [7:0]        addr_lo_q;
    logic [ADDR_W-9:0] addr_hi_q;
    logic [7:0]        len_lo_q;
    logic [LEN_W-9:0]  len_hi_q;
    logic [7:0]        value_q;
    logic [7:0]        stride_q;

    // Working copies latched at START
    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        wstride_q, wstride_d;
    logic [7:0]        wvalue_q, wvalue_d;
    logic [2:0]        mask_q, mask_d;
    logic              vb_only_q, vb_only_d;

    logic             wr_pulse, ctrl_wr, start, ack, abort, grant;
    logic [LEN_W-1:0] len_raw, len_eff;

    // Writes act only on the rising edge of reg_cs & reg_wr, so a long strobe is one write.
    always_comb begin
        wr_pulse = reg_cs & reg_wr & ~wr_q;
        ctrl_wr  = wr_pulse && (reg_addr == 3'd6);
        abort    = ctrl_wr & reg_din[7];
        start    = ctrl_wr & reg_din[0] & ~reg_din[7];
        ack      = ctrl_wr & reg_din[6];
        len_raw  = {len_hi_q, len_lo_q};
        len_eff  = (len_raw > MAX_LEN) ? MAX_LEN : len_raw;
        // An abort seen this cycle suppresses the write so nothing lands after it.
        grant    = (state_q == ST_RUN) && !cpu_vram_req && (!vb_only_q || vblank) && !abort;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q      <= 1'b0;
            addr_lo_q <= '0;
            addr_hi_q <= '0;
            len_lo_q  <= '0;
            len_hi_q  <= '0;
            value_q   <= '0;
            stride_q  <= '0;
        end else begin
            wr_q <= reg_cs & reg_wr;
            if (wr_pulse && (state_q == ST_IDLE)) begin
                case (reg_addr)
                    3'd0:    addr_lo_q <= reg_din;
                    3'd1:    addr_hi_q <= reg_din[ADDR_W-9:0];
                    3'd2:    len_lo_q  <= reg_din;
                    3'd3:    len_hi_q  <= reg_din[LEN_W-9:0];
                    3'd4:    value_q   <= reg_din;
                    3'd5:    stride_q  <= reg_din;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            waddr_q   <= '0;
            cnt_q     <= '0;
            wstride_q <= '0;
            wvalue_q  <= '0;
            mask_q    <= '0;
            vb_only_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            waddr_q   <= waddr_d;
            cnt_q     <= cnt_d;
            wstride_q <= wstride_d;
            wvalue_q  <= wvalue_d;
            mask_q    <= mask_d;
            vb_only_q <= vb_only_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        waddr_d   = waddr_q;
        cnt_d     = cnt_q;
        wstride_d = wstride_q;
        wvalue_d  = wvalue_q;
        mask_d    = mask_q;
        vb_only_d = vb_only_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_d    = 1'b0;
                    waddr_d   = {addr_hi_q, addr_lo_q};
                    cnt_d     = len_eff;
                    wstride_d = (stride_q == 8'd0) ? 8'd1 : stride_q;
                    wvalue_d  = value_q;
                    mask_d    = reg_din[4:2];
                    vb_only_d = reg_din[1];
                    if ((len_eff == '0) || (reg_din[4:2] == 3'b000)) begin
                        done_d = 1'b1;
                    end else if (reg_din[1] && !vblank) begin
                        state_d = ST_WAIT_VB;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_WAIT_VB: begin
                if (vblank) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (grant) begin
                    waddr_d = waddr_q + ADDR_W'(wstride_q);
                    cnt_d   = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (vb_only_q && !vblank) begin
                    state_d = ST_WAIT_VB;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
        // ACK is applied last so ACK+START leaves done cleared even for an empty job.
        if (ack) begin
            done_d = 1'b0;
        end
    end

    always_comb begin
        case (reg_addr)
            3'd0:    reg_dout = addr_lo_q;
            3'd1:    reg_dout = 8'(addr_hi_q);
            3'd2:    reg_dout = len_lo_q;
            3'd3:    reg_dout = 8'(len_hi_q);
            3'd4:    reg_dout = value_q;
            3'd5:    reg_dout = stride_q;
            3'd7:    reg_dout = {5'b0, (state_q == ST_WAIT_VB), done_q, (state_q != ST_IDLE)};
            default: reg_dout = 8'h00;
        endcase
    end

    assign fill_addr = waddr_q;
    assign fill_data = wvalue_q;
    assign fill_we   = grant ? mask_q : 3'b000;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_vram_fill_ctrl.sv
// tb/tb_vram_fill_ctrl.sv - directed self-checking bench for vram_fill_ctrl
module tb_vram_fill_ctrl;

    logic        clk_sys;
    logic        reset_n;
    logic        reg_cs;
    logic        reg_wr;
    logic [2:0]  reg_addr;
    logic [7:0]  reg_din;
    logic [7:0]  reg_dout;
    logic        cpu_vram_req;
    logic        vblank;
    logic [10:0] fill_addr;
    logic [7:0]  fill_data;
    logic [2:0]  fill_we;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [10:0] log_addr[$];
    logic [2:0]  log_we[$];
    logic [7:0]  log_data[$];
    int          log_cyc[$];
    logic [2:0]  we_or;

    vram_fill_ctrl #(.ADDR_W(11), .LEN_W(12)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .reg_cs       (reg_cs),
        .reg_wr       (reg_wr),
        .reg_addr     (reg_addr),
        .reg_din      (reg_din),
        .reg_dout     (reg_dout),
        .cpu_vram_req (cpu_vram_req),
        .vblank       (vblank),
        .fill_addr    (fill_addr),
        .fill_data    (fill_data),
        .fill_we      (fill_we),
        .busy         (busy),
        .done         (done)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Inputs change 1ns after the rising edge; the write port is observed on the falling edge.
    always @(negedge clk_sys) begin
        cyc++;
        if (fill_we != 3'b000) begin
            log_addr.push_back(fill_addr);
            log_we.push_back(fill_we);
            log_data.push_back(fill_data);
            log_cyc.push_back(cyc);
            we_or = we_or | fill_we;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_we.delete();
        log_data.delete();
        log_cyc.delete();
        we_or = 3'b000;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        reg_cs   = 1'b1;
        reg_wr   = 1'b1;
        reg_addr = a;
        reg_din  = d;
        tick();
        reg_cs = 1'b0;
        reg_wr = 1'b0;
        tick();
    endtask

    // Leaves the bench in the first cycle after the CTRL write is accepted.
    task automatic start_ctrl(input logic [7:0] d);
        reg_cs   = 1'b1;
        reg_wr   = 1'b1;
        reg_addr = 3'd6;
        reg_din  = d;
        tick();
        reg_cs = 1'b0;
        reg_wr = 1'b0;
    endtask

    task automatic prog(input logic [10:0] a, input logic [11:0] len,
                        input logic [7:0] stride, input logic [7:0] value);
        wr_reg(3'd0, a[7:0]);
        wr_reg(3'd1, {5'b0, a[10:8]});
        wr_reg(3'd2, len[7:0]);
        wr_reg(3'd3, {4'b0, len[11:8]});
        wr_reg(3'd4, value);
        wr_reg(3'd5, stride);
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (busy && (n < max_cycles)) begin
            tick();
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic read_reg(input logic [2:0] a, input string tag, input logic [7:0] exp);
        reg_addr = a;
        #1;
        check(tag, reg_dout, exp);
    endtask

    initial begin
        reset_n      = 1'b0;
        reg_cs       = 1'b0;
        reg_wr       = 1'b0;
        reg_addr     = 3'd7;
        reg_din      = 8'h00;
        cpu_vram_req = 1'b0;
        vblank       = 1'b0;
        we_or        = 3'b000;
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_we", fill_we, 3'b000);
        check("reset_status", reg_dout, 8'h00);
        tick();
        reset_n = 1'b1;
        tick();

        // Basic fill into char RAM only
        prog(11'h010, 12'd4, 8'd1, 8'h41);
        read_reg(3'd0, "readback_addr_lo", 8'h10);
        read_reg(3'd4, "readback_value", 8'h41);
        clear_log();
        start_ctrl(8'h05);
        #1;
        check("basic_first_we", fill_we, 3'b001);
        check("basic_first_addr", fill_addr, 11'h010);
        check("basic_first_data", fill_data, 8'h41);
        wait_idle("basic_timeout", 20);
        check("basic_count", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("basic_addr", log_addr[i], 11'h010 + i);
                check("basic_we", log_we[i], 3'b001);
            end
            check("basic_consecutive", log_cyc[3] - log_cyc[0], 3);
        end
        check("basic_only_chram", we_or, 3'b001);
        check("basic_done", done, 1'b1);
        read_reg(3'd7, "basic_status", 8'h02);
        wr_reg(3'd6, 8'h40);
        check("ack_clears_done", done, 1'b0);

        // Stride 40 with wrap past the top of the 2 KiB space, fg+bg targets
        prog(11'h7F0, 12'd3, 8'd40, 8'h41);
        clear_log();
        start_ctrl(8'h19);
        wait_idle("wrap_timeout", 20);
        check("wrap_count", log_addr.size(), 3);
        check("wrap_addr0", log_addr[0], 11'h7F0);
        check("wrap_addr1", log_addr[1], 11'h018);
        check("wrap_addr2", log_addr[2], 11'h040);
        check("wrap_mask", we_or, 3'b110);

        // CPU priority: three stalled cycles inside a 10-write job
        tick();
        prog(11'h100, 12'd10, 8'd1, 8'h22);
        clear_log();
        start_ctrl(8'h05);
        tick();
        tick();
        cpu_vram_req = 1'b1;
        #1;
        check("cpu_stall_we", fill_we, 3'b000);
        check("cpu_stall_busy", busy, 1'b1);
        tick();
        tick();
        tick();
        cpu_vram_req = 1'b0;
        wait_idle("cpu_timeout", 30);
        check("cpu_count", log_addr.size(), 10);
        if (log_addr.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                check("cpu_addr", log_addr[i], 11'h100 + i);
            end
            check("cpu_span", log_cyc[9] - log_cyc[0], 12);
        end

        // Vblank-only job: first vblank cycle switches WAIT_VB to RUN, writes follow
        tick();
        prog(11'h200, 12'd8, 8'd2, 8'h5A);
        clear_log();
        vblank = 1'b0;
        start_ctrl(8'h13);
        read_reg(3'd7, "vb_status_wait", 8'h05);
        check("vb_no_write", fill_we, 3'b000);
        tick();
        tick();
        tick();
        check("vb_idle_count", log_addr.size(), 0);
        vblank = 1'b1;
        repeat (6) tick();
        vblank = 1'b0;
        repeat (3) tick();
        check("vb_first_burst", log_addr.size(), 5);
        read_reg(3'd7, "vb_status_paused", 8'h05);
        vblank = 1'b1;
        repeat (5) tick();
        vblank = 1'b0;
        check("vb_total", log_addr.size(), 8);
        if (log_addr.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("vb_addr", log_addr[i], 11'h200 + 2 * i);
            end
        end
        check("vb_mask", we_or, 3'b100);
        read_reg(3'd7, "vb_status_done", 8'h02);
        read_reg(3'd6, "ctrl_reads_zero", 8'h00);
        tick();

        // Empty jobs: zero length, zero mask, ACK together with START
        prog(11'h000, 12'd0, 8'd1, 8'h00);
        clear_log();
        start_ctrl(8'h05);
        check("len0_busy", busy, 1'b0);
        check("len0_done", done, 1'b1);
        tick();
        start_ctrl(8'h45);
        check("ack_start_done", done, 1'b0);
        tick();
        wr_reg(3'd2, 8'd4);
        start_ctrl(8'h01);
        check("mask0_done", done, 1'b1);
        check("mask0_busy", busy, 1'b0);
        repeat (3) tick();
        check("empty_jobs_writes", log_addr.size(), 0);

        // Oversized length clamps to the full 2048 locations; stride 0 steps by 1
        prog(11'h005, 12'hFFF, 8'd0, 8'h33);
        clear_log();
        start_ctrl(8'h05);
        tick();
        wr_reg(3'd0, 8'hAA);
        read_reg(3'd0, "busy_write_ignored", 8'h05);
        wait_idle("full_timeout", 2200);
        check("full_count", log_addr.size(), 2048);
        check("full_first", log_addr[0], 11'h005);
        check("full_second", log_addr[1], 11'h006);
        check("full_last", log_addr[2047], 11'h004);
        check("full_done", done, 1'b1);

        // Abort after two writes
        tick();
        prog(11'h300, 12'd10, 8'd1, 8'h77);
        clear_log();
        start_ctrl(8'h05);
        tick();
        tick();
        reg_cs   = 1'b1;
        reg_wr   = 1'b1;
        reg_addr = 3'd6;
        reg_din  = 8'h80;
        #1;
        check("abort_we_now", fill_we, 3'b000);
        tick();
        reg_cs = 1'b0;
        reg_wr = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        repeat (4) tick();
        check("abort_count", log_addr.size(), 2);

        // Asynchronous reset in the middle of a run
        prog(11'h111, 12'd10, 8'd1, 8'h99);
        start_ctrl(8'h05);
        tick();
        #2;
        reset_n = 1'b0;
        reg_addr = 3'd7;
        #1;
        check("areset_we", fill_we, 3'b000);
        check("areset_busy", busy, 1'b0);
        check("areset_addr", fill_addr, 11'h000);
        check("areset_data", fill_data, 8'h00);
        check("areset_status", reg_dout, 8'h00);
        tick();
        reset_n = 1'b1;
        tick();
        prog(11'h020, 12'd2, 8'd1, 8'h55);
        clear_log();
        start_ctrl(8'h09);
        wait_idle("post_reset_timeout", 10);
        check("post_reset_count", log_addr.size(), 2);
        check("post_reset_addr0", log_addr[0], 11'h020);
        check("post_reset_addr1", log_addr[1], 11'h021);
        check("post_reset_data", log_data[1], 8'h55);
        check("post_reset_mask", we_or, 3'b010);
        check("post_reset_done", done, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
